// File: rtl/pause_sequencer.sv
// Pause sequencer: merges the user button, OSD and external pause requests,
// freezes the CPU only on a frame boundary (vblank edge or watchdog), grants
// per-requester acknowledges while frozen, and dims the picture during long pauses.
module pause_sequencer #(
    parameter int unsigned CLKSPD  = 12,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned SEC_CYC = CLKSPD * 1000000,
    parameter int unsigned WD_CYC  = SEC_CYC / 10,
    parameter int unsigned DIM_SEC = 10
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            vblank,
    input  logic            user_button,
    input  logic [NREQ-1:0] pause_req,
    input  logic [1:0]      options,
    input  logic            OSD_STATUS,
    output logic            pause_cpu,
    output logic [NREQ-1:0] pause_ack,
    output logic [1:0]      dim_level
);

    // Watchdog bounds the wait for a vblank edge when video timing is absent.
    localparam int unsigned WD_W = (WD_CYC > 1) ? $clog2(WD_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((WD_CYC > 0) ? WD_CYC - 1 : 0);

    localparam int unsigned DIM_W = 32;
    localparam logic [DIM_W-1:0] DIM_SAT = {DIM_W{1'b1}};

    // Clamp a 64-bit threshold into the 32-bit dim counter range.
    function automatic logic [DIM_W-1:0] clamp32(input logic [63:0] v);
        if (v > 64'(DIM_SAT)) begin
            return DIM_SAT;
        end
        return v[DIM_W-1:0];
    endfunction

    localparam logic [63:0] TH1_RAW = 64'(DIM_SEC) * 64'(SEC_CYC);
    localparam logic [63:0] TH2_RAW = TH1_RAW + 64'(SEC_CYC);
    localparam logic [63:0] TH3_RAW = TH2_RAW + 64'(SEC_CYC);
    localparam logic [DIM_W-1:0] DIM_TH1 = clamp32(TH1_RAW);
    localparam logic [DIM_W-1:0] DIM_TH2 = clamp32(TH2_RAW);
    localparam logic [DIM_W-1:0] DIM_TH3 = clamp32(TH3_RAW);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTER  = 2'd1,
        PAUSED = 2'd2,
        EXIT   = 2'd3
    } state_t;

    state_t            state;
    logic [WD_W-1:0]   wd_cnt;
    logic              btn_prev;
    logic              vb_prev;
    logic              toggle;
    logic              btn_edge;
    logic              vb_edge;
    logic              eff_req;
    logic              wd_done;
    logic              dim_en;
    logic [DIM_W-1:0]  dim_cnt;
    logic [DIM_W-1:0]  dim_cnt_nxt;

    assign btn_edge = user_button & ~btn_prev;
    assign vb_edge  = vblank & ~vb_prev;
    assign eff_req  = (|pause_req) | toggle | (OSD_STATUS & options[0]);
    assign wd_done  = (wd_cnt == WD_LAST);

    // Edge history for the button and vblank, plus the user pause toggle.
    always_ff @(posedge clk_sys) begin
        btn_prev <= user_button;
        if (reset) begin
            vb_prev <= 1'b0;
            toggle  <= 1'b0;
        end else begin
            vb_prev <= vblank;
            toggle  <= toggle ^ btn_edge;
        end
    end

    // Pause FSM: enter and leave the frozen state only on a frame boundary.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= RUN;
            wd_cnt    <= '0;
            pause_cpu <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (eff_req) begin
                        state  <= ENTER;
                        wd_cnt <= '0;
                    end
                end
                ENTER: begin
                    if (!eff_req) begin
                        state <= RUN;
                    end else if (vb_edge || wd_done) begin
                        state     <= PAUSED;
                        pause_cpu <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                PAUSED: begin
                    if (!eff_req) begin
                        state  <= EXIT;
                        wd_cnt <= '0;
                    end
                end
                EXIT: begin
                    if (eff_req) begin
                        state <= PAUSED;
                    end else if (vb_edge || wd_done) begin
                        state     <= RUN;
                        pause_cpu <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state     <= RUN;
                    wd_cnt    <= '0;
                    pause_cpu <= 1'b0;
                end
            endcase
        end
    end

    // Grants follow the requests directly so a dropped request releases at once.
    assign pause_ack = (state == PAUSED) ? pause_req : '0;

    // Map the dim counter onto an attenuation step.
    function automatic logic [1:0] level_of(input logic [DIM_W-1:0] cnt);
        if (cnt >= DIM_TH3) begin
            return 2'd3;
        end else if (cnt >= DIM_TH2) begin
            return 2'd2;
        end else if (cnt >= DIM_TH1) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    assign dim_en = pause_cpu & options[1];

    // Saturating dim counter; clears whenever dimming is not active.
    always_comb begin
        dim_cnt_nxt = '0;
        if (dim_en) begin
            dim_cnt_nxt = (dim_cnt == DIM_SAT) ? dim_cnt : dim_cnt + DIM_W'(1);
        end
    end

    // Dim level tracks the counter register value it is registered with.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dim_cnt   <= '0;
            dim_level <= 2'd0;
        end else begin
            dim_cnt   <= dim_cnt_nxt;
            dim_level <= dim_en ? level_of(dim_cnt_nxt) : 2'd0;
        end
    end

endmodule

// File: tb/tb_pause_sequencer.sv
// Directed bench for pause_sequencer: vector table plus multi-cycle sequences.
module tb_pause_sequencer;

    localparam int unsigned NREQ = 4;

    logic            clk_sys;
    logic            reset;
    logic            vblank;
    logic            user_button;
    logic [NREQ-1:0] pause_req;
    logic [1:0]      options;
    logic            OSD_STATUS;
    logic            pause_cpu;
    logic [NREQ-1:0] pause_ack;
    logic [1:0]      dim_level;

    int tests = 0;
    int fails = 0;

    pause_sequencer #(
        .NREQ    (NREQ),
        .SEC_CYC (100),
        .WD_CYC  (10),
        .DIM_SEC (2)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .vblank      (vblank),
        .user_button (user_button),
        .pause_req   (pause_req),
        .options     (options),
        .OSD_STATUS  (OSD_STATUS),
        .pause_cpu   (pause_cpu),
        .pause_ack   (pause_ack),
        .dim_level   (dim_level)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       vb;
        logic [1:0] opt;
        logic       osd;
        logic       cpu;
        logic [3:0] ack;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic vb,
                                input logic [1:0] opt, input logic osd,
                                input logic cpu, input logic [3:0] ack);
        vec_t v;
        v.rst = rst; v.req = req; v.vb = vb; v.opt = opt; v.osd = osd;
        v.cpu = cpu; v.ack = ack;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cpu(input logic val, input string name);
        int k;
        k = 0;
        while (pause_cpu !== val && k < 40) begin
            tick();
            k++;
        end
        check(name, 32'(pause_cpu), 32'(val));
    endtask

    initial begin
        vec_t v;

        reset = 1'b1; vblank = 1'b0; user_button = 1'b0;
        pause_req = '0; options = 2'b00; OSD_STATUS = 1'b0;
        tick();
        tick();
        check("reset cpu", 32'(pause_cpu), 32'd0);
        check("reset ack", 32'(pause_ack), 32'd0);
        check("reset dim", 32'(dim_level), 32'd0);
        reset = 1'b0;

        //          rst req     vb    opt    osd   cpu   ack
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 1, 2'b00, 0, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b0010, 1, 2'b00, 0, 1, 4'b0010));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 1, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 1, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0100, 1, 2'b00, 0, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b1000, 0, 2'b00, 0, 1, 4'b1000));
        vecs.push_back(mk(0, 4'b1001, 0, 2'b00, 0, 1, 4'b1001));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 1, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 1, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 1, 2'b00, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b01, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 1, 2'b01, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 1, 2'b01, 1, 1, 4'b0000));
        vecs.push_back(mk(1, 4'b0000, 1, 2'b01, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 0, 2'b00, 0, 0, 4'b0000));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset = v.rst; pause_req = v.req; vblank = v.vb;
            options = v.opt; OSD_STATUS = v.osd;
            tick();
            check($sformatf("vec%0d cpu", i), 32'(pause_cpu), 32'(v.cpu));
            check($sformatf("vec%0d ack", i), 32'(pause_ack), 32'(v.ack));
            check($sformatf("vec%0d dim", i), 32'(dim_level), 32'd0);
        end
        reset = 1'b0;

        // Watchdog entry and exit with vblank held low.
        pause_req = 4'b0001;
        for (int e = 1; e <= 10; e++) tick();
        check("wd enter early cpu", 32'(pause_cpu), 32'd0);
        tick();
        check("wd enter cpu", 32'(pause_cpu), 32'd1);
        check("wd enter ack", 32'(pause_ack), 32'h1);
        pause_req = 4'b0000;
        tick();
        check("wd exit start cpu", 32'(pause_cpu), 32'd1);
        check("wd exit start ack", 32'(pause_ack), 32'd0);
        for (int e = 1; e <= 9; e++) tick();
        check("wd exit early cpu", 32'(pause_cpu), 32'd1);
        tick();
        check("wd exit cpu", 32'(pause_cpu), 32'd0);

        // Reset while paused with the request still held, then normal re-entry.
        pause_req = 4'b0001;
        tick();
        vblank = 1'b1;
        tick();
        check("held pause cpu", 32'(pause_cpu), 32'd1);
        reset = 1'b1;
        tick();
        check("held reset cpu", 32'(pause_cpu), 32'd0);
        check("held reset ack", 32'(pause_ack), 32'd0);
        reset = 1'b0; vblank = 1'b0;
        tick();
        check("held reenter cpu", 32'(pause_cpu), 32'd0);
        vblank = 1'b1;
        tick();
        check("held repause cpu", 32'(pause_cpu), 32'd1);
        check("held repause ack", 32'(pause_ack), 32'h1);
        pause_req = 4'b0000; vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        check("held release cpu", 32'(pause_cpu), 32'd0);
        vblank = 1'b0;
        tick();

        // Dim ramp during a button-toggled pause.
        options = 2'b10;
        user_button = 1'b1;
        tick();
        user_button = 1'b0;
        wait_cpu(1'b1, "dim pause start");
        for (int m = 1; m <= 1000; m++) begin
            tick();
            if (m == 199) check("dim m199", 32'(dim_level), 32'd0);
            if (m == 200) check("dim m200", 32'(dim_level), 32'd1);
            if (m == 299) check("dim m299", 32'(dim_level), 32'd1);
            if (m == 300) check("dim m300", 32'(dim_level), 32'd2);
            if (m == 399) check("dim m399", 32'(dim_level), 32'd2);
            if (m == 400) check("dim m400", 32'(dim_level), 32'd3);
            if (m == 1000) check("dim m1000", 32'(dim_level), 32'd3);
        end
        user_button = 1'b1;
        tick();
        user_button = 1'b0;
        wait_cpu(1'b0, "dim pause end");
        check("dim at release", 32'(dim_level), 32'd3);
        tick();
        check("dim after release", 32'(dim_level), 32'd0);

        // Dim disable mid-pause, then reset clears the toggle.
        user_button = 1'b1;
        tick();
        user_button = 1'b0;
        wait_cpu(1'b1, "dim2 pause start");
        for (int m = 1; m <= 250; m++) tick();
        check("dim2 level", 32'(dim_level), 32'd1);
        options = 2'b00;
        tick();
        check("dim2 off level", 32'(dim_level), 32'd0);
        check("dim2 off cpu", 32'(pause_cpu), 32'd1);
        reset = 1'b1;
        tick();
        check("rst paused cpu", 32'(pause_cpu), 32'd0);
        check("rst paused ack", 32'(pause_ack), 32'd0);
        check("rst paused dim", 32'(dim_level), 32'd0);
        reset = 1'b0;
        for (int e = 0; e < 20; e++) tick();
        check("toggle cleared cpu", 32'(pause_cpu), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
